// File: rtl/seven_seg_scanner.sv
// Four-digit hex scanner: time-multiplexes a double-buffered 16-bit value onto
// one shared segment bus with active-low anodes, ghost blanking and leading-zero blanking.
module seven_seg_scanner #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic        load,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [3:0]  nibble,
  output logic [3:0]  an,
  output logic        dp,
  output logic [1:0]  digit_idx,
  output logic        pending
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic [CW-1:0] cnt_r, cnt_s;
  logic [1:0]    idx_r, idx_s;
  logic [15:0]   disp_r, disp_s;
  logic [3:0]    disp_dp_r, disp_dp_s;
  logic [19:0]   pend_r, pend_s;
  logic          pending_r, pending_s;
  logic [3:0]    nibble_r, nibble_s;
  logic [3:0]    an_r, an_s;
  logic          dp_r, dp_s;
  logic          tick_s, commit_s, lz_s, lit_s;

  // Next-state for prescaler, scan index and the double buffer.
  always_comb begin
    tick_s    = (cnt_r == CW'(REFRESH_DIV - 1));
    cnt_s     = cnt_r + CW'(1);
    idx_s     = idx_r;
    commit_s  = 1'b0;
    disp_s    = disp_r;
    disp_dp_s = disp_dp_r;
    pend_s    = pend_r;
    pending_s = pending_r;
    if (tick_s) begin
      cnt_s    = '0;
      idx_s    = idx_r + 2'd1;
      commit_s = (idx_r == 2'd3) && pending_r;
    end else begin
      cnt_s    = cnt_r + CW'(1);
    end
    // A commit always takes the old buffer, even when a load lands on the boundary.
    if (commit_s) begin
      {disp_dp_s, disp_s} = pend_r;
    end else begin
      {disp_dp_s, disp_s} = {disp_dp_r, disp_r};
    end
    if (load) begin
      pend_s    = {dp_in, value};
      pending_s = 1'b1;
    end else if (commit_s) begin
      pending_s = 1'b0;
    end else begin
      pending_s = pending_r;
    end
  end

  // Digit outputs, computed from next-state so they line up with digit_idx.
  always_comb begin
    case (idx_s)
      2'd1:    lz_s = (disp_s[15:4] == 12'h000);
      2'd2:    lz_s = (disp_s[15:8] == 8'h00);
      2'd3:    lz_s = (disp_s[15:12] == 4'h0);
      default: lz_s = 1'b0;
    endcase
    lit_s    = (cnt_s >= CW'(BLANK_CYC)) && !(blank_lz && lz_s && !disp_dp_s[idx_s]);
    nibble_s = disp_s[4*idx_s +: 4];
    if (lit_s) begin
      an_s = ~(4'b0001 << idx_s);
      dp_s = ~disp_dp_s[idx_s];
    end else begin
      an_s = 4'b1111;
      dp_s = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r     <= '0;
      idx_r     <= 2'd0;
      disp_r    <= 16'h0000;
      disp_dp_r <= 4'b0000;
      pend_r    <= 20'h00000;
      pending_r <= 1'b0;
      nibble_r  <= 4'h0;
      an_r      <= 4'b1111;
      dp_r      <= 1'b1;
    end else begin
      cnt_r     <= cnt_s;
      idx_r     <= idx_s;
      disp_r    <= disp_s;
      disp_dp_r <= disp_dp_s;
      pend_r    <= pend_s;
      pending_r <= pending_s;
      nibble_r  <= nibble_s;
      an_r      <= an_s;
      dp_r      <= dp_s;
    end
  end

  assign nibble    = nibble_r;
  assign an        = an_r;
  assign dp        = dp_r;
  assign digit_idx = idx_r;
  assign pending   = pending_r;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with REFRESH_DIV=4, BLANK_CYC=1.
module tb_seven_seg_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = 16'h0000;
  logic        load = 1'b0;
  logic [3:0]  dp_in = 4'b0000;
  logic        blank_lz = 1'b0;
  logic [3:0]  nibble;
  logic [3:0]  an;
  logic        dp;
  logic [1:0]  digit_idx;
  logic        pending;

  int checks = 0;
  int errors = 0;
  int k = 0;

  seven_seg_scanner #(.REFRESH_DIV(4), .BLANK_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .dp_in(dp_in),
    .blank_lz(blank_lz), .nibble(nibble), .an(an), .dp(dp),
    .digit_idx(digit_idx), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one clock; sample on the following falling edge
  task automatic step();
    @(posedge clk);
    k++;
    @(negedge clk);
  endtask

  task automatic run_to(input int target);
    while (k < target) step();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp_in = d;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  logic [3:0] nib_tab [4] = '{4'hF, 4'h2, 4'hA, 4'h1};
  logic [3:0] an_tab  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_an", {12'h0, an}, 16'h000F);
    chk("rst_dp", {15'h0, dp}, 16'h0001);
    chk("rst_nib", {12'h0, nibble}, 16'h0000);
    chk("rst_pend", {15'h0, pending}, 16'h0000);
    rst_n = 1'b1;
    k = 0;

    // scan of one full frame
    do_load(16'h1A2F, 4'b0000);
    chk("scan_pend_set", {15'h0, pending}, 16'h0001);
    run_to(16);
    chk("scan_pend_clr", {15'h0, pending}, 16'h0000);
    chk("scan_gap0", {12'h0, an}, 16'h000F);
    for (int s = 0; s < 4; s++) begin
      for (int c = 1; c < 4; c++) begin
        step();
        chk("scan_idx", {14'h0, digit_idx}, 16'(s));
        chk("scan_an", {12'h0, an}, {12'h0, an_tab[s]});
        chk("scan_nib", {12'h0, nibble}, {12'h0, nib_tab[s]});
        chk("scan_dp", {15'h0, dp}, 16'h0001);
      end
      step();
      chk("scan_gap_an", {12'h0, an}, 16'h000F);
      chk("scan_gap_dp", {15'h0, dp}, 16'h0001);
    end

    // asynchronous reset in mid-slot discards pending value
    do_load(16'h1234, 4'b0000);
    run_to(34);
    chk("pre_rst_an", {12'h0, an}, 16'h000E);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_an", {12'h0, an}, 16'h000F);
    chk("mid_rst_dp", {15'h0, dp}, 16'h0001);
    chk("mid_rst_nib", {12'h0, nibble}, 16'h0000);
    chk("mid_rst_pend", {15'h0, pending}, 16'h0000);
    chk("mid_rst_idx", {14'h0, digit_idx}, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    run_to(3);
    chk("post_rst_idx3", {14'h0, digit_idx}, 16'h0000);
    step();
    chk("post_rst_tick", {14'h0, digit_idx}, 16'h0001);
    run_to(17);
    chk("post_rst_disp", {12'h0, nibble}, 16'h0000);
    chk("post_rst_pend", {15'h0, pending}, 16'h0000);

    // double buffer: last load wins, current frame untouched
    do_load(16'h1A2F, 4'b0000);
    run_to(36);
    do_load(16'h1234, 4'b0000);
    chk("buf_old1", {12'h0, nibble}, 16'h0002);
    chk("buf_pend", {15'h0, pending}, 16'h0001);
    run_to(40);
    do_load(16'h5678, 4'b0000);
    chk("buf_old2", {12'h0, nibble}, 16'h000A);
    run_to(45);
    chk("buf_old3", {12'h0, nibble}, 16'h0001);
    run_to(49);
    chk("buf_pend_clr", {15'h0, pending}, 16'h0000);
    chk("buf_new0", {12'h0, nibble}, 16'h0008);
    run_to(53);
    chk("buf_new1", {12'h0, nibble}, 16'h0007);

    // load colliding with a frame boundary
    do_load(16'h0C0D, 4'b0000);
    chk("col_new1b", {12'h0, nibble}, 16'h0007);
    run_to(57);
    chk("buf_new2", {12'h0, nibble}, 16'h0006);
    run_to(61);
    chk("buf_new3", {12'h0, nibble}, 16'h0005);
    run_to(63);
    do_load(16'hBEEF, 4'b0000);
    chk("col_pend_kept", {15'h0, pending}, 16'h0001);
    run_to(65);
    chk("col_f1_d0", {12'h0, nibble}, 16'h000D);
    run_to(69);
    chk("col_f1_d1", {12'h0, nibble}, 16'h0000);
    run_to(73);
    chk("col_f1_d2", {12'h0, nibble}, 16'h000C);
    run_to(77);
    chk("col_f1_d3", {12'h0, nibble}, 16'h0000);
    chk("col_f1_an3", {12'h0, an}, 16'h0007);
    run_to(81);
    chk("col_f2_pend", {15'h0, pending}, 16'h0000);
    chk("col_f2_d0", {12'h0, nibble}, 16'h000F);
    run_to(85);
    chk("col_f2_d1", {12'h0, nibble}, 16'h000E);
    run_to(89);
    chk("col_f2_d2", {12'h0, nibble}, 16'h000E);
    run_to(93);
    chk("col_f2_d3", {12'h0, nibble}, 16'h000B);

    // leading-zero blanking
    blank_lz = 1'b1;
    do_load(16'h0040, 4'b0000);
    run_to(97);
    chk("lz40_an0", {12'h0, an}, 16'h000E);
    chk("lz40_nib0", {12'h0, nibble}, 16'h0000);
    run_to(101);
    chk("lz40_an1", {12'h0, an}, 16'h000D);
    chk("lz40_nib1", {12'h0, nibble}, 16'h0004);
    run_to(105);
    chk("lz40_an2", {12'h0, an}, 16'h000F);
    run_to(109);
    chk("lz40_an3", {12'h0, an}, 16'h000F);
    do_load(16'h0000, 4'b0000);
    run_to(113);
    chk("lz0_an0", {12'h0, an}, 16'h000E);
    chk("lz0_nib0", {12'h0, nibble}, 16'h0000);
    run_to(117);
    chk("lz0_an1", {12'h0, an}, 16'h000F);
    run_to(121);
    chk("lz0_an2", {12'h0, an}, 16'h000F);
    run_to(125);
    chk("lz0_an3", {12'h0, an}, 16'h000F);
    do_load(16'h0000, 4'b1000);
    run_to(129);
    chk("lzdp_an0", {12'h0, an}, 16'h000E);
    chk("lzdp_dp0", {15'h0, dp}, 16'h0001);
    run_to(133);
    chk("lzdp_an1", {12'h0, an}, 16'h000F);
    run_to(137);
    chk("lzdp_an2", {12'h0, an}, 16'h000F);
    run_to(141);
    chk("lzdp_an3", {12'h0, an}, 16'h0007);
    chk("lzdp_dp3", {15'h0, dp}, 16'h0000);
    dp_in = 4'b0000;

    // invariants under random loads
    for (int n = 0; n < 10000; n++) begin
      value    = 16'($urandom);
      dp_in    = 4'($urandom);
      blank_lz = 1'($urandom);
      load     = ($urandom_range(0, 7) == 0);
      step();
      chk("inv_onehot", {15'h0, ($countones(~an) <= 1)}, 16'h0001);
      if (k % 4 == 0) begin
        chk("inv_gap", {12'h0, an}, 16'h000F);
      end else begin
        chk("inv_gap_off", 16'h0000, 16'h0000 & {12'h0, an});
      end
      if (an == 4'b1111) begin
        chk("inv_dp", {15'h0, dp}, 16'h0001);
      end else begin
        chk("inv_lit_idx", {12'h0, an}, {12'h0, ~(4'b0001 << digit_idx)});
      end
    end
    load = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
